// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA game front end.
package vga_pkg;

    // Per-button debounce states
    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    // 10 ms at a 65 MHz pixel clock
    localparam int DEBOUNCE_CYCLES_DEFAULT = 650000;
    localparam int XY_W_DEFAULT            = 12;

endpackage

// File: rtl/mouse_click_conditioner_button.sv
// button_debouncer: 2-flop synchroniser, debounce FSM and counter for one button.
// The release pulse port is called rel because release is a reserved word.
// accept is a combinational early copy of the press condition, so the parent
// can capture coordinates on the same edge that registers the press pulse.
module button_debouncer
    import vga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic accept
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;

    // Bring the possibly asynchronous raw button into the clk domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // High on the cycle whose closing edge will register the press pulse
    assign accept = (state == PRESS_WAIT) && sync2 && (cnt == CNT_LAST);

    // Debounce FSM; counter is cleared on each wait-state entry and stops at CNT_LAST
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync2) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= HELD;
                        press <= 1'b1;
                        level <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!sync2) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        rel   <= 1'b1;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mouse_click_conditioner.sv
// Mouse front end: debounced button levels, press/release pulses and the
// cursor position latched at each accepted press.
module mouse_click_conditioner
    import vga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int XY_W            = XY_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            left_raw,
    input  logic            right_raw,
    input  logic [XY_W-1:0] xpos,
    input  logic [XY_W-1:0] ypos,
    output logic            MouseLeft,
    output logic            MouseRight,
    output logic            left_press,
    output logic            right_press,
    output logic            left_release,
    output logic            right_release,
    output logic [XY_W-1:0] click_x,
    output logic [XY_W-1:0] click_y
);

    logic left_accept;
    logic right_accept;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clk    (clk),
        .rst    (rst),
        .raw    (left_raw),
        .level  (MouseLeft),
        .press  (left_press),
        .rel    (left_release),
        .accept (left_accept)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clk    (clk),
        .rst    (rst),
        .raw    (right_raw),
        .level  (MouseRight),
        .press  (right_press),
        .rel    (right_release),
        .accept (right_accept)
    );

    // Latch the live cursor on the edge that registers either press (once if both)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            click_x <= '0;
            click_y <= '0;
        end else if (left_accept || right_accept) begin
            click_x <= xpos;
            click_y <= ypos;
        end
    end

endmodule

// File: tb/tb_mouse_click_conditioner.sv
// Bench for mouse_click_conditioner: reference model predicts every cycle's
// outputs into a scoreboard queue, a monitor pops and compares on negedge.
module tb_mouse_click_conditioner;

    localparam int D = 4;
    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         left_raw = 1'b0;
    logic         right_raw = 1'b0;
    logic [W-1:0] xpos = '0;
    logic [W-1:0] ypos = '0;
    logic         MouseLeft, MouseRight;
    logic         left_press, right_press, left_release, right_release;
    logic [W-1:0] click_x, click_y;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic         ml, mr, lp, rp, lr, rr;
        logic [W-1:0] cx, cy;
    } obs_t;

    obs_t sb[$];

    // Model state: accepted level, length of the current disagreement run,
    // and the raw samples from one and two edges ago.
    bit           lvl[2];
    int           run[2];
    bit           past1[2];
    bit           past2[2];
    logic [W-1:0] mcx = '0;
    logic [W-1:0] mcy = '0;

    mouse_click_conditioner #(.DEBOUNCE_CYCLES(D), .XY_W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .left_raw      (left_raw),
        .right_raw     (right_raw),
        .xpos          (xpos),
        .ypos          (ypos),
        .MouseLeft     (MouseLeft),
        .MouseRight    (MouseRight),
        .left_press    (left_press),
        .right_press   (right_press),
        .left_release  (left_release),
        .right_release (right_release),
        .click_x       (click_x),
        .click_y       (click_y)
    );

    always #5 clk = ~clk;

    // Reference: a level flips once the raw input, seen two edges late, has
    // disagreed with it on D+1 consecutive edges.
    always @(posedge clk) begin
        obs_t e;
        bit   rawv[2];
        bit   pr[2];
        bit   rl[2];
        bit   seen;
        e = '0;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                lvl[i] = 0; run[i] = 0; past1[i] = 0; past2[i] = 0;
            end
            mcx = '0;
            mcy = '0;
        end else begin
            rawv[0] = left_raw;
            rawv[1] = right_raw;
            for (int i = 0; i < 2; i++) begin
                pr[i] = 0;
                rl[i] = 0;
                seen  = past2[i];
                if (seen != lvl[i]) begin
                    run[i]++;
                    if (run[i] == D + 1) begin
                        lvl[i] = seen;
                        run[i] = 0;
                        pr[i]  = seen;
                        rl[i]  = !seen;
                    end
                end else begin
                    run[i] = 0;
                end
                past2[i] = past1[i];
                past1[i] = rawv[i];
            end
            if (pr[0] || pr[1]) begin
                mcx = xpos;
                mcy = ypos;
            end
            e.ml = lvl[0]; e.mr = lvl[1];
            e.lp = pr[0];  e.rp = pr[1];
            e.lr = rl[0];  e.rr = rl[1];
            e.cx = mcx;    e.cy = mcy;
        end
        sb.push_back(e);
    end

    // Monitor: compare DUT outputs against the oldest prediction
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                obs_t e, g;
                e = sb.pop_front();
                g = {MouseLeft, MouseRight, left_press, right_press,
                     left_release, right_release, click_x, click_y};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL cycle t=%0t got lvl=%b%b prs=%b%b rel=%b%b xy=%0d,%0d exp lvl=%b%b prs=%b%b rel=%b%b xy=%0d,%0d",
                             $time, g.ml, g.mr, g.lp, g.rp, g.lr, g.rr, g.cx, g.cy,
                             e.ml, e.mr, e.lp, e.rp, e.lr, e.rr, e.cx, e.cy);
                end
            end
        end
    end

    task automatic step(input logic l, input logic r, input int x, input int y);
        left_raw  = l;
        right_raw = r;
        xpos      = W'(x);
        ypos      = W'(y);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit   lv, rv;
        int   hl, hr;
        obs_t g;
        repeat (3) step(0, 0, 0, 0);
        rst = 1'b1;
        repeat (4) step(0, 0, 0, 0);
        // clean press
        repeat (10) step(1, 0, 300, 200);
        // release with a bounce
        repeat (2) step(0, 0, 300, 200);
        step(1, 0, 300, 200);
        repeat (10) step(0, 0, 300, 200);
        // glitch rejection
        repeat (3) step(1, 0, 11, 22);
        repeat (8) step(0, 0, 33, 44);
        // simultaneous press and release
        repeat (10) step(1, 1, 512, 384);
        repeat (10) step(0, 0, 512, 384);
        // moving cursor during debounce
        for (int i = 0; i < 12; i++) step(1, 0, 100 + i * 7, 50 + i * 3);
        repeat (10) step(0, 0, 0, 0);
        // reset with left in PRESS_WAIT, counter at 2
        repeat (5) step(1, 0, 5, 6);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        g = {MouseLeft, MouseRight, left_press, right_press,
             left_release, right_release, click_x, click_y};
        checks++;
        if (g !== '0) begin
            errors++;
            $display("FAIL reset_async got %h exp 0", g);
        end
        repeat (2) step(1, 0, 7, 7);
        rst = 1'b1;
        repeat (10) step(1, 0, 9, 9);
        repeat (10) step(0, 0, 9, 9);
        // randomized hold lengths on both buttons, live cursor
        lv = 0; rv = 0; hl = 0; hr = 0;
        for (int n = 0; n < 1500; n++) begin
            if (hl == 0) begin lv = !lv; hl = $urandom_range(1, 9); end
            if (hr == 0) begin rv = !rv; hr = $urandom_range(1, 9); end
            step(lv, rv, $urandom_range(0, 4095), $urandom_range(0, 4095));
            hl--;
            hr--;
        end
        repeat (3) step(0, 0, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
